// File: rtl/parking_pkg.sv
// Shared types and sizing helpers for the parking-lot controller.
// Gate FSM state encoding and timer width derivation.
package parking_pkg;

    typedef enum logic [1:0] {
        G_IDLE,
        G_OPEN,
        G_CLOSE
    } gate_state_t;

    localparam int GATE_TIMEOUT_DEF = 8;
    localparam int TMR_W_DEF        = $clog2(GATE_TIMEOUT_DEF);

    // Timer must hold 0..timeout-1 and never collapse to zero width.
    function automatic int tmr_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier gate: idle/open/close sequencing with open timeout and an
// optional rate-limited deny pulse for requests refused while not allowed.
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEF,
    parameter bit DENY_EN      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic allowed,
    input  logic pass,
    output logic gate_open,
    output logic cnt_pulse,
    output logic timeout_pulse,
    output logic deny_pulse
);

    localparam int               TMR_W    = tmr_width(GATE_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    gate_state_t      r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_gate_open;
    logic             r_timeout;
    logic             r_deny;

    // In G_IDLE the timer doubles as the deny countdown; in G_OPEN it counts up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= G_IDLE;
            r_timer     <= '0;
            r_gate_open <= 1'b0;
            r_timeout   <= 1'b0;
            r_deny      <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_deny    <= 1'b0;
            case (r_state)
                G_IDLE: begin
                    if (req && allowed) begin
                        r_state     <= G_OPEN;
                        r_gate_open <= 1'b1;
                        r_timer     <= '0;
                    end else if (DENY_EN && req) begin
                        if (r_timer == '0) begin
                            r_deny  <= 1'b1;
                            r_timer <= TMR_LAST;
                        end else begin
                            r_timer <= r_timer - TMR_ONE;
                        end
                    end else begin
                        r_timer <= '0;
                    end
                end
                G_OPEN: begin
                    if (pass) begin
                        r_state     <= G_CLOSE;
                        r_gate_open <= 1'b0;
                    end else if (r_timer == TMR_LAST) begin
                        r_state     <= G_CLOSE;
                        r_gate_open <= 1'b0;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_ONE;
                    end
                end
                G_CLOSE: begin
                    r_state <= G_IDLE;
                    r_timer <= '0;
                end
                default: begin
                    r_state     <= G_IDLE;
                    r_timer     <= '0;
                    r_gate_open <= 1'b0;
                end
            endcase
        end
    end

    assign gate_open     = r_gate_open;
    assign timeout_pulse = r_timeout;
    assign deny_pulse    = r_deny;
    // Count strobe lands on the same edge that closes the gate.
    assign cnt_pulse     = (r_state == G_OPEN) && pass;

endmodule

// File: rtl/parking_ctrl_mlane.sv
// Parking-lot controller: independent entry/exit gates sharing one
// occupancy counter with full/almost_full/empty status decode.
module parking_ctrl_mlane
    import parking_pkg::*;
#(
    parameter int CAPACITY     = 16,
    parameter int CNT_W        = $clog2(CAPACITY + 1),
    parameter int GATE_TIMEOUT = GATE_TIMEOUT_DEF,
    parameter int AF_MARGIN    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             entry_pass,
    input  logic             exit_req,
    input  logic             exit_pass,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic             entry_denied,
    output logic [1:0]       timeout_err
);

    localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] AF_V  = CNT_W'(CAPACITY - AF_MARGIN);
    localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

    logic [CNT_W-1:0] r_occ;
    logic             w_full;
    logic             w_empty;
    logic             w_inc;
    logic             w_dec;
    logic             w_entry_to;
    logic             w_exit_to;
    logic             w_entry_deny;
    logic             w_exit_deny_unused;

    parking_gate_fsm #(
        .GATE_TIMEOUT (GATE_TIMEOUT),
        .DENY_EN      (1'b1)
    ) u_entry_gate (
        .clk           (clk),
        .rst           (rst),
        .req           (entry_req),
        .allowed       (!w_full),
        .pass          (entry_pass),
        .gate_open     (entry_gate_open),
        .cnt_pulse     (w_inc),
        .timeout_pulse (w_entry_to),
        .deny_pulse    (w_entry_deny)
    );

    parking_gate_fsm #(
        .GATE_TIMEOUT (GATE_TIMEOUT),
        .DENY_EN      (1'b0)
    ) u_exit_gate (
        .clk           (clk),
        .rst           (rst),
        .req           (exit_req),
        .allowed       (!w_empty),
        .pass          (exit_pass),
        .gate_open     (exit_gate_open),
        .cnt_pulse     (w_dec),
        .timeout_pulse (w_exit_to),
        .deny_pulse    (w_exit_deny_unused)
    );

    // Simultaneous inc/dec cancel; bounds are held defensively.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (w_inc && !w_dec && (r_occ != CAP_V)) begin
            r_occ <= r_occ + ONE_V;
        end else if (w_dec && !w_inc && (r_occ != '0)) begin
            r_occ <= r_occ - ONE_V;
        end
    end

    assign w_full       = (r_occ == CAP_V);
    assign w_empty      = (r_occ == '0);

    assign occupancy    = r_occ;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_occ >= AF_V);
    assign entry_denied = w_entry_deny;
    assign timeout_err  = {w_exit_to, w_entry_to};

endmodule

// File: tb/tb_parking_ctrl_mlane.sv
// Directed bench for parking_ctrl_mlane at CAPACITY=4, GATE_TIMEOUT=5, AF_MARGIN=1.
module tb_parking_ctrl_mlane;

    logic       clk;
    logic       rst;
    logic       entry_req;
    logic       entry_pass;
    logic       exit_req;
    logic       exit_pass;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic [2:0] occupancy;
    logic       full;
    logic       almost_full;
    logic       empty;
    logic       entry_denied;
    logic [1:0] timeout_err;

    int total = 0;
    int bad   = 0;

    parking_ctrl_mlane #(
        .CAPACITY     (4),
        .GATE_TIMEOUT (5),
        .AF_MARGIN    (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .entry_req       (entry_req),
        .entry_pass      (entry_pass),
        .exit_req        (exit_req),
        .exit_pass       (exit_pass),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .occupancy       (occupancy),
        .full            (full),
        .almost_full     (almost_full),
        .empty           (empty),
        .entry_denied    (entry_denied),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_entry();
        entry_req = 1'b1;
        step(1);
        entry_pass = 1'b1;
        entry_req  = 1'b0;
        step(1);
        entry_pass = 1'b0;
        step(1);
    endtask

    task automatic do_exit();
        exit_req = 1'b1;
        step(1);
        exit_pass = 1'b1;
        exit_req  = 1'b0;
        step(1);
        exit_pass = 1'b0;
        step(1);
    endtask

    initial begin
        rst        = 1'b0;
        entry_req  = 1'b0;
        entry_pass = 1'b0;
        exit_req   = 1'b0;
        exit_pass  = 1'b0;
        step(2);

        chk("rst_entry_open", entry_gate_open, 0);
        chk("rst_exit_open", exit_gate_open, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_deny", entry_denied, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b1;
        step(1);

        // first entry with exact latency
        entry_req = 1'b1;
        chk("e1_closed_before", entry_gate_open, 0);
        step(1);
        chk("e1_open_c3", entry_gate_open, 1);
        step(1);
        chk("e1_open_c4", entry_gate_open, 1);
        chk("e1_occ_before", occupancy, 0);
        entry_pass = 1'b1;
        entry_req  = 1'b0;
        step(1);
        entry_pass = 1'b0;
        chk("e1_closed_c5", entry_gate_open, 0);
        chk("e1_occ", occupancy, 1);
        chk("e1_empty", empty, 0);
        step(1);

        // fill the lot
        do_entry();
        chk("occ2", occupancy, 2);
        chk("occ2_af", almost_full, 0);
        do_entry();
        chk("occ3", occupancy, 3);
        chk("occ3_af", almost_full, 1);
        chk("occ3_full", full, 0);
        do_entry();
        chk("occ4", occupancy, 4);
        chk("occ4_full", full, 1);
        chk("occ4_af", almost_full, 1);

        // denied entry, pulse repeats every 5 cycles while held
        entry_req = 1'b1;
        step(1);
        chk("deny_pulse1", entry_denied, 1);
        chk("deny_gate", entry_gate_open, 0);
        step(1);
        chk("deny_gap1", entry_denied, 0);
        step(3);
        chk("deny_gap4", entry_denied, 0);
        step(1);
        chk("deny_pulse2", entry_denied, 1);
        entry_req = 1'b0;
        step(1);
        chk("deny_end", entry_denied, 0);
        chk("deny_occ", occupancy, 4);

        // make room, then time out the entry gate
        do_exit();
        chk("exit_occ3", occupancy, 3);
        chk("exit_full", full, 0);
        entry_req = 1'b1;
        step(1);
        entry_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("to_open", entry_gate_open, 1);
            chk("to_nopulse", timeout_err, 0);
            step(1);
        end
        chk("to_closed", entry_gate_open, 0);
        chk("to_pulse", timeout_err, 2'b01);
        chk("to_occ", occupancy, 3);
        step(1);
        chk("to_pulse_end", timeout_err, 0);

        // simultaneous pass on both gates at occupancy 2
        do_exit();
        chk("sim_pre_occ", occupancy, 2);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        step(1);
        chk("sim_entry_open", entry_gate_open, 1);
        chk("sim_exit_open", exit_gate_open, 1);
        entry_pass = 1'b1;
        exit_pass  = 1'b1;
        entry_req  = 1'b0;
        exit_req   = 1'b0;
        step(1);
        entry_pass = 1'b0;
        exit_pass  = 1'b0;
        chk("sim_occ", occupancy, 2);
        chk("sim_entry_closed", entry_gate_open, 0);
        chk("sim_exit_closed", exit_gate_open, 0);
        step(1);

        // drain, then exit request on an empty lot and stray passes
        do_exit();
        do_exit();
        chk("drain_occ", occupancy, 0);
        chk("drain_empty", empty, 1);
        exit_req = 1'b1;
        step(2);
        chk("empty_exit_closed", exit_gate_open, 0);
        chk("empty_exit_to", timeout_err, 0);
        chk("empty_exit_deny", entry_denied, 0);
        exit_req  = 1'b0;
        exit_pass = 1'b1;
        step(1);
        exit_pass = 1'b0;
        chk("stray_exit_occ", occupancy, 0);
        entry_pass = 1'b1;
        step(1);
        entry_pass = 1'b0;
        chk("stray_entry_occ", occupancy, 0);

        // pass on the last open cycle wins over timeout
        do_entry();
        do_entry();
        entry_req = 1'b1;
        step(1);
        entry_req = 1'b0;
        step(4);
        chk("edge_open_last", entry_gate_open, 1);
        entry_pass = 1'b1;
        step(1);
        entry_pass = 1'b0;
        chk("edge_occ", occupancy, 3);
        chk("edge_no_to", timeout_err, 0);
        chk("edge_closed", entry_gate_open, 0);
        step(1);

        // asynchronous reset while the entry gate is open
        entry_req = 1'b1;
        step(1);
        chk("mid_open", entry_gate_open, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_gate", entry_gate_open, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_empty", empty, 1);
        entry_req = 1'b0;
        #2;
        rst = 1'b1;
        step(2);
        chk("post_rst_gate", entry_gate_open, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_ctrl_mlane.md
Name: parking_ctrl_mlane

Overview:
- Parametrised parking-lot controller with independent entry and exit gates.
- Each gate has its own open/pass/timeout FSM; a shared occupancy counter is updated only when a car is confirmed passing the beam sensor.
- Provides full, almost_full and empty status, a deny pulse and a timeout pulse for the lot display and alarm logic.

Parameters:
- CAPACITY, 16, number of parking slots (>=2).
- CNT_W, $clog2(CAPACITY+1), occupancy counter width.
- GATE_TIMEOUT, 8, cycles a gate stays open waiting for a pass before auto-closing (>=2).
- AF_MARGIN, 2, almost_full asserts when occupancy >= CAPACITY-AF_MARGIN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- entry_req  in  1  car present at entry loop (level).
- entry_pass  in  1  entry beam broken, car passed (1-cycle pulse).
- exit_req  in  1  car present at exit loop (level).
- exit_pass  in  1  exit beam broken, car passed (1-cycle pulse).
- entry_gate_open  out  1  entry barrier raised.
- exit_gate_open  out  1  exit barrier raised.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- almost_full  out  1  occupancy >= CAPACITY-AF_MARGIN.
- empty  out  1  occupancy == 0.
- entry_denied  out  1  1-cycle pulse: entry request refused because lot is full.
- timeout_err  out  2  per-gate 1-cycle pulse, bit0 entry, bit1 exit: gate timed out without a pass.

Behaviour:
- Reset (rst=0, async): all gate FSMs G_IDLE, occupancy=0, gate_open outputs 0, entry_denied=0, timeout_err=0, full=0, almost_full=0, empty=1.
- All outputs are registered or decoded directly from registers; no combinational path from inputs to outputs.
- Gate FSM states, per gate:
  - G_IDLE: if req && allowed, go to G_OPEN and load timer=0. Entry allowed = !full; exit allowed = !empty.
  - G_OPEN: gate_open=1; timer increments each cycle.
    - pass=1: go to G_CLOSE and issue a one-cycle count pulse (inc for entry, dec for exit).
    - timer==GATE_TIMEOUT-1 with no pass: go to G_CLOSE and pulse timeout_err.
    - pass and timeout in the same cycle: pass wins, no timeout.
  - G_CLOSE: gate_open=0 for exactly 1 cycle, then G_IDLE. A req still held is re-evaluated from G_IDLE, so the next open comes 2 cycles after close.
- Latency: req sampled at edge t gives gate_open=1 after edge t+1; a pass at edge t gives gate_open=0 and updated occupancy after edge t+1.
- Deny: entry_req sampled in G_IDLE with full=1 gives entry_denied=1 for one cycle. While req is held and full persists, the pulse repeats every GATE_TIMEOUT cycles (deny timer) rather than every cycle. Exit requests with empty=1 are silently ignored.
- Counter: next = occupancy + inc - dec.
  - Simultaneous inc and dec leaves occupancy unchanged.
  - Overflow is impossible: entry opens only when occupancy < CAPACITY, and occupancy can only fall while the entry gate is open.
  - Underflow is impossible by the symmetric argument.
  - The counter also saturates defensively at 0 and CAPACITY.
- pass pulses outside G_OPEN are ignored, with no count change.
- Status flags are decoded from the occupancy register and are valid in the same cycle occupancy changes.
- Reset mid-operation: gates close immediately and the count clears.

Decomposition:
- Package parking_pkg:
  - gate_state_t enum {G_IDLE, G_OPEN, G_CLOSE}.
  - Localparam for timer width $clog2(GATE_TIMEOUT).
- Sub-module parking_gate_fsm (req, allowed, pass → gate_open, cnt_pulse, timeout_pulse, deny_pulse), instantiated twice.
- The top level holds the occupancy counter and status decode.

Test Plan (CAPACITY=4, GATE_TIMEOUT=5, AF_MARGIN=1):
- Reset, then entry_req=1 at cycle 2 and entry_pass at cycle 4 → entry_gate_open high cycles 3-4, low cycle 5; occupancy=1 at cycle 5; empty drops.
- Four entries → occupancy=4, full=1, almost_full=1 from occupancy=3. A fifth entry_req → entry_denied pulse, gate stays closed, occupancy stays 4.
- Entry gate opened with no pass → gate_open high exactly 5 cycles, then timeout_err[0] pulse, occupancy unchanged.
- At occupancy=2, both gates open and entry_pass and exit_pass arrive in the same cycle → occupancy stays 2; both gates close next cycle.
- exit_req at occupancy=0 → no gate open, no pulse. A stray exit_pass while exit gate is idle → occupancy unchanged.
- rst asserted while entry gate is open at occupancy=3 → immediately gate_open=0, occupancy=0, empty=1.
